// File: rtl/demux_slot_sequencer_if.sv
// demux_slot_sequencer_if: upstream handshake plus demux/frame outputs of the slot sequencer.
//   Enable, Slot_Mask[3:0] : run request and slot enables
//   In_Data, In_Valid      : serial bit stream in
//   In_Ready               : sequencer accepts a bit this cycle
//   A[1:0], In, Strobe     : demux select, data, delivered-bit qualifier
//   Frame_Start            : first strobe cycle of a frame
//   Frame_Count            : completed frames (wraps)
//   Busy                   : sequencer not idle
interface demux_slot_sequencer_if #(
   parameter int FCNT_W = 8
);
   logic              Enable;
   logic [3:0]        Slot_Mask;
   logic              In_Data;
   logic              In_Valid;
   logic              In_Ready;
   logic [1:0]        A;
   logic              In;
   logic              Strobe;
   logic              Frame_Start;
   logic [FCNT_W-1:0] Frame_Count;
   logic              Busy;
   modport master (
      output Enable, Slot_Mask, In_Data, In_Valid,
      input  In_Ready, A, In, Strobe, Frame_Start, Frame_Count, Busy
   );
   modport slave (
      input  Enable, Slot_Mask, In_Data, In_Valid,
      output In_Ready, A, In, Strobe, Frame_Start, Frame_Count, Busy
   );
endinterface

// File: rtl/demux_slot_sequencer.sv
// demux_slot_sequencer: deals a serial bit stream round-robin across enabled 1-to-4 demux slots.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of demux_slot_sequencer_if (handshake in, demux select/data/strobe
//           and frame framing out)
module demux_slot_sequencer #(
   parameter int DWELL  = 1,
   parameter int FCNT_W = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   demux_slot_sequencer_if.slave       bus
);
   localparam int DW = DWELL > 1 ? $clog2(DWELL) : 1;
   typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;
   state_t            state_q, state_d;
   logic [3:0]        mask_q, mask_d;
   logic [DW-1:0]     dwell_q, dwell_d;
   logic [1:0]        a_q, a_d;
   logic              in_q, in_d, strobe_q, strobe_d, fs_q, fs_d, first_q, first_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   logic [3:0]        above;
   logic              start, wrap;
   // An empty mask yields index 0, which is also the idle select value.
   function automatic logic [1:0] low_idx(input logic [3:0] m);
      return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : {2{m[3]}};
   endfunction
   // Slots strictly above the current one that are still enabled this frame.
   assign above = mask_q & 4'(4'b1110 << a_q);
   assign wrap  = above == 4'b0;
   assign start = bus.Enable && |bus.Slot_Mask;
   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      dwell_d = dwell_q;
      a_d     = a_q;
      in_d    = in_q;
      strobe_d = strobe_q;
      fs_d    = 1'b0;
      first_d = first_q;
      fcnt_d  = fcnt_q;
      case (state_q)
         IDLE: if (start) begin
            mask_d  = bus.Slot_Mask;
            a_d     = low_idx(bus.Slot_Mask);
            first_d = 1'b1;
            state_d = LOAD;
         end
         LOAD: if (bus.In_Valid) begin
            in_d     = bus.In_Data;
            strobe_d = 1'b1;
            dwell_d  = '0;
            fs_d     = first_q;
            first_d  = 1'b0;
            state_d  = HOLD;
         end
         HOLD: begin
            dwell_d = dwell_q + DW'(1);
            if (dwell_q == DW'(DWELL - 1)) begin
               strobe_d = 1'b0;
               in_d     = 1'b0;
               state_d  = LOAD;
               a_d      = low_idx(wrap ? mask_q : above);
               if (wrap) begin
                  fcnt_d = fcnt_q + FCNT_W'(1);
                  // Frame boundary: the only point where run request and mask are re-sampled.
                  if (start) begin
                     mask_d  = bus.Slot_Mask;
                     a_d     = low_idx(bus.Slot_Mask);
                     first_d = 1'b1;
                  end else begin
                     a_d     = 2'd0;
                     state_d = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         mask_q   <= '0;
         dwell_q  <= '0;
         a_q      <= '0;
         in_q     <= 1'b0;
         strobe_q <= 1'b0;
         fs_q     <= 1'b0;
         first_q  <= 1'b0;
         fcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         mask_q   <= mask_d;
         dwell_q  <= dwell_d;
         a_q      <= a_d;
         in_q     <= in_d;
         strobe_q <= strobe_d;
         fs_q     <= fs_d;
         first_q  <= first_d;
         fcnt_q   <= fcnt_d;
      end
   end
   assign bus.In_Ready    = state_q == LOAD;
   assign bus.Busy        = state_q != IDLE;
   assign bus.A           = a_q;
   assign bus.In          = in_q;
   assign bus.Strobe      = strobe_q;
   assign bus.Frame_Start = fs_q;
   assign bus.Frame_Count = fcnt_q;
endmodule

// File: doc/demux_slot_sequencer.md
# demux_slot_sequencer

Upstream feeder for the 1-to-4 demultiplexer. It accepts a serial bit stream over a valid/ready handshake and deals the bits round-robin across the enabled output slots. It drives the demux select `A[1:0]` and data `In` directly. `Strobe` qualifies each delivered bit. Frame framing and a frame counter go to downstream capture logic.

## Interface
Parameters:
- `DWELL`, default 1: cycles each delivered bit is held on `A`/`In`; legal range 1..16.
- `FCNT_W`, default 8: width of `Frame_Count`.

Ports:
- `clk` input 1: the only clock; all state changes on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `Enable` input 1: run request; sampled only in IDLE and at frame boundaries.
- `Slot_Mask` input 4: bit k=1 enables slot k; sampled only in IDLE and at frame boundaries.
- `In_Data` input 1: serial data bit.
- `In_Valid` input 1: `In_Data` is valid.
- `In_Ready` output 1: sequencer accepts a bit this cycle.
- `A` output 2: demux select (current slot index).
- `In` output 1: demux data.
- `Strobe` output 1: `A`/`In` carry a delivered bit.
- `Frame_Start` output 1: one-cycle pulse on the first strobe cycle of each frame.
- `Frame_Count` output `FCNT_W`: count of completed frames.
- `Busy` output 1: high in any state other than IDLE.

## Operation
- Internal state:
  - State register: IDLE, LOAD, HOLD.
  - `act_mask[3:0]`: latched slot mask.
  - `dwell_cnt`: 0..DWELL-1.
  - `first_slot` flag.
- IDLE:
  - `In_Ready`=0.
  - If `Enable`=1 and `Slot_Mask`≠0:
    - latch `act_mask`<=`Slot_Mask`;
    - `A`<=lowest set bit index;
    - set `first_slot`;
    - go LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - `In_Ready`=1.
  - On `In_Valid`&&`In_Ready`:
    - `In`<=`In_Data`, `Strobe`<=1, `dwell_cnt`<=0;
    - `Frame_Start`<=`first_slot`, then clear `first_slot`;
    - go HOLD.
  - Without valid: stay; `Strobe`=0, `In`=0, `A` holds.
- HOLD:
  - `In_Ready`=0; `Strobe`=1; `A` and `In` held.
  - `dwell_cnt` increments each cycle.
  - On `dwell_cnt`=DWELL-1 (last hold cycle), on the closing edge:
    - `Strobe`<=0, `In`<=0;
    - advance `A` to the next set bit of `act_mask` above the current index, circularly.
- End of frame:
  - A frame ends when that advance wraps, i.e. no set bit exists above the current index. A single-slot mask wraps every bit.
  - `Frame_Count`<=`Frame_Count`+1, modulo 2^FCNT_W (255→0 at default width).
  - Re-sample `Enable`/`Slot_Mask`:
    - If `Enable`=1 and mask≠0: `act_mask`<=mask, `A`<=lowest set bit, set `first_slot`, go LOAD.
    - Otherwise go IDLE with `A`<=0.
- Not at end of frame: go LOAD.
- Changes to `Enable`/`Slot_Mask` mid-frame have no effect until the boundary. A frame in progress always completes, even if that takes arbitrarily long waiting for `In_Valid`.
- `Frame_Start` is high only in the first HOLD cycle of the first slot of a frame.

## Timing
- Reset values (asynchronous):
  - state=IDLE;
  - `A`=0, `In`=0, `Strobe`=0, `In_Ready`=0, `Frame_Start`=0, `Busy`=0;
  - `Frame_Count`=0, `act_mask`=0.
- Reset asserted mid-HOLD clears all outputs immediately, without waiting for an edge. The in-flight bit is dropped.
- `Enable` seen high in IDLE at edge e: LOAD (`In_Ready`=1) from e+1.
- Handshake at edge t:
  - `Strobe`/`In`/`A` valid from t+1 through t+DWELL;
  - `In_Ready` high again at t+DWELL+1.
- Peak throughput: one bit per DWELL+1 cycles.
- `Frame_Count` update is visible at t+DWELL+1 after the last slot's handshake.
- `In_Ready` is a decode of the state register only; there is no combinational path from `In_Valid`.
- `A` changes only while `Strobe`=0, so the demux never glitches between slots during a strobe.

## Test plan
- Reset, then release with `Enable`=0 -> all outputs 0, `Busy`=0, `In_Ready`=0 for 20 cycles.
- DWELL=1, mask=1111, `In_Valid`=1, data 1,0,1,1 -> `A`=0,1,2,3 with `In`=1,0,1,1; each `Strobe` one cycle, spaced 2 cycles; `Frame_Start` with `A`=0 only; `Frame_Count` 0→1 after `A`=3.
- Mask=1010, DWELL=3 -> `A` sequence 1,3,1,3; each strobe 3 cycles long; `Frame_Start` when `A`=1; `Frame_Count` increments after each `A`=3 bit.
- `In_Valid` held low 5 cycles in LOAD at `A`=2 -> `Strobe`=0, `In`=0, `A`=2 held, `In_Ready`=1; delivery resumes on the next valid.
- Mid-frame, set `Enable`=0 and mask=0001 -> current frame finishes on the old mask; then IDLE, `Busy`=0. Re-enable with mask=0000 -> stays IDLE.
- Preload 255 frames, complete one more -> `Frame_Count` wraps to 0. Assert `rst_n` low mid-HOLD -> `Strobe`/`In`/`A`/`Frame_Count` are 0 before the next edge.
